// File: rtl/sliding_window_3x3.sv
// 3x3 sliding window over a raster pixel stream using two line buffers.
// Optional FRAME_SYNC_EN adds a sof input that resyncs the position to (0,0).
module sliding_window_3x3 #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int PIX_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef FRAME_SYNC_EN
    input  logic             sof,
`endif
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic [PIX_W-1:0] sw_pixel_1,
    output logic [PIX_W-1:0] sw_pixel_2,
    output logic [PIX_W-1:0] sw_pixel_3,
    output logic [PIX_W-1:0] sw_pixel_4,
    output logic [PIX_W-1:0] sw_pixel_5,
    output logic [PIX_W-1:0] sw_pixel_6,
    output logic [PIX_W-1:0] sw_pixel_7,
    output logic [PIX_W-1:0] sw_pixel_8,
    output logic [PIX_W-1:0] sw_pixel_9,
    output logic             act
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]    col_cnt;
    logic [CW-1:0]    col_pos;
    logic [CW-1:0]    col_nxt;
    logic [RW-1:0]    row_cnt;
    logic [RW-1:0]    row_pos;
    logic [RW-1:0]    row_nxt;
    logic             col_last;
    logic             row_last;
    logic             frame_start;
    logic             win_full;
    logic             wr_en;

    logic [PIX_W-1:0] lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] lb2 [IMG_WIDTH];
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] lb2_rd;
    logic [PIX_W-1:0] win [9];

`ifdef FRAME_SYNC_EN
    assign frame_start = sof;
`else
    assign frame_start = 1'b0;
`endif

    // Position of the pixel being accepted; sof overrides the counters.
    always_comb begin
        col_pos  = frame_start ? '0 : col_cnt;
        row_pos  = frame_start ? '0 : row_cnt;
        col_last = (col_pos == CW'(IMG_WIDTH - 1));
        row_last = (row_pos == RW'(IMG_HEIGHT - 1));
        col_nxt  = col_last ? '0 : col_pos + 1'b1;
        row_nxt  = row_pos;
        if (col_last) begin
            row_nxt = row_last ? '0 : row_pos + 1'b1;
        end
        win_full = (row_pos >= RW'(2)) && (col_pos >= CW'(2));
    end

    assign wr_en  = pix_valid && !rst;
    assign lb1_rd = lb1[col_pos];
    assign lb2_rd = lb2[col_pos];

    // Line buffers are never cleared; act gating hides stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lb1[col_pos] <= pix_in;
            lb2[col_pos] <= lb1_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
            act     <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else if (pix_valid) begin
            win[0]  <= win[1];
            win[1]  <= win[2];
            win[2]  <= lb2_rd;
            win[3]  <= win[4];
            win[4]  <= win[5];
            win[5]  <= lb1_rd;
            win[6]  <= win[7];
            win[7]  <= win[8];
            win[8]  <= pix_in;
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
            act     <= win_full;
        end else begin
            act <= 1'b0;
        end
    end

    assign sw_pixel_1 = win[0];
    assign sw_pixel_2 = win[1];
    assign sw_pixel_3 = win[2];
    assign sw_pixel_4 = win[3];
    assign sw_pixel_5 = win[4];
    assign sw_pixel_6 = win[5];
    assign sw_pixel_7 = win[6];
    assign sw_pixel_8 = win[7];
    assign sw_pixel_9 = win[8];

endmodule

// File: tb/tb_sliding_window_3x3.sv
// Scoreboard bench for sliding_window_3x3 on a 4x4 image.
// Expected windows are queued as pixels are sent; a monitor checks them.
module tb_sliding_window_3x3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pix_in;
    logic       pix_valid;
`ifdef FRAME_SYNC_EN
    logic       sof;
`endif
    logic [7:0] sw1, sw2, sw3, sw4, sw5, sw6, sw7, sw8, sw9;
    logic       act;

    int total = 0;
    int bad   = 0;

    logic [71:0] exp_q [$];
    logic [71:0] win_now;
    logic [71:0] win_prev;
    logic        v_edge;
    logic        r_edge;

    // Hand-computed windows of the 0..15 frame, in output order.
    int exp_tab [4][9] = '{
        '{0, 1, 2, 4, 5, 6, 8, 9, 10},
        '{1, 2, 3, 5, 6, 7, 9, 10, 11},
        '{4, 5, 6, 8, 9, 10, 12, 13, 14},
        '{5, 6, 7, 9, 10, 11, 13, 14, 15}
    };

    sliding_window_3x3 #(
        .IMG_WIDTH (4),
        .IMG_HEIGHT(4),
        .PIX_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef FRAME_SYNC_EN
        .sof       (sof),
`endif
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sw_pixel_1(sw1),
        .sw_pixel_2(sw2),
        .sw_pixel_3(sw3),
        .sw_pixel_4(sw4),
        .sw_pixel_5(sw5),
        .sw_pixel_6(sw6),
        .sw_pixel_7(sw7),
        .sw_pixel_8(sw8),
        .sw_pixel_9(sw9),
        .act       (act)
    );

    always #5 clk = ~clk;

    assign win_now = {sw9, sw8, sw7, sw6, sw5, sw4, sw3, sw2, sw1};

    function automatic logic [71:0] mk_win(int idx, int base);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) begin
            w[8*i +: 8] = 8'(exp_tab[idx][i] + base);
        end
        return w;
    endfunction

    always @(posedge clk) begin
        v_edge <= pix_valid;
        r_edge <= rst;
    end

    // Monitor: pops on act, checks act gating and bubble stability.
    initial begin
        win_prev = '0;
        forever begin
            @(negedge clk);
            if (act) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_act: got window %h, none expected",
                             win_now);
                end else begin
                    logic [71:0] e;
                    e = exp_q.pop_front();
                    if (win_now !== e) begin
                        bad++;
                        $display("FAIL window: got %h want %h", win_now, e);
                    end
                end
            end
            if (v_edge === 1'b0 && r_edge === 1'b0) begin
                total++;
                if (act !== 1'b0 || win_now !== win_prev) begin
                    bad++;
                    $display("FAIL bubble_hold: act=%b win=%h want act=0 win=%h",
                             act, win_now, win_prev);
                end
            end
            win_prev = win_now;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_px(int val, bit push, int idx, int base);
        pix_in    = 8'(val);
        pix_valid = 1'b1;
        if (push) exp_q.push_back(mk_win(idx, base));
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic send_frame(int base, bit gaps);
        for (int k = 0; k < 16; k++) begin
            bit p;
            int idx;
            p   = (k == 10) || (k == 11) || (k == 14) || (k == 15);
            idx = (k == 10) ? 0 : (k == 11) ? 1 : (k == 14) ? 2 : 3;
            send_px(base + k, p, idx, base);
            if (gaps) begin
                int g;
                g = $urandom_range(1, 3);
                repeat (g) tick();
            end
        end
    endtask

    task automatic check_cleared(string name);
        total++;
        if (act !== 1'b0 || win_now !== '0) begin
            bad++;
            $display("FAIL %s: act=%b win=%h want act=0 win=0",
                     name, act, win_now);
        end
    endtask

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_in    = '0;
`ifdef FRAME_SYNC_EN
        sof       = 1'b0;
`endif
        tick();
        tick();
        check_cleared("reset_state");
        rst = 1'b0;
        tick();

        send_frame(0, 1'b0);
        tick();
        send_frame(0, 1'b1);
        tick();
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        tick();

        for (int k = 0; k < 7; k++) send_px(k, 1'b0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cleared("mid_frame_reset");
        send_frame(0, 1'b0);
        tick();

        for (int k = 0; k < 3; k++) send_px(k, 1'b0, 0, 0);
        rst       = 1'b1;
        pix_valid = 1'b1;
        pix_in    = 8'd99;
        tick();
        rst       = 1'b0;
        pix_valid = 1'b0;
        check_cleared("reset_with_valid");
        send_frame(0, 1'b0);
        tick();

`ifdef FRAME_SYNC_EN
        for (int k = 0; k < 6; k++) send_px(k, 1'b0, 0, 0);
        sof = 1'b1;
        send_px(0, 1'b0, 0, 0);
        sof = 1'b0;
        for (int k = 1; k < 16; k++) begin
            bit p;
            int idx;
            p   = (k == 10) || (k == 11) || (k == 14) || (k == 15);
            idx = (k == 10) ? 0 : (k == 11) ? 1 : (k == 14) ? 2 : 3;
            send_px(k, p, idx, 0);
        end
        tick();
`endif

        repeat (5) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_act: got %0d windows pending want 0",
                     exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sliding_window_3x3.md
Name: sliding_window_3x3

Overview:
- Upstream neighbour of the pixel filter pipeline. Accepts a raster-order pixel stream, one pixel per cycle when valid.
- Buffers two full image lines and emits the 3x3 neighbourhood as sw_pixel_1..sw_pixel_9, together with the act strobe, which is the filter's input qualifier.
- Emits only windows that lie fully inside the image, so there are (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.

Parameters:
- IMG_WIDTH, 256, pixels per line (>=3); sets line buffer depth.
- IMG_HEIGHT, 256, lines per frame (>=3); row counter wrap point.
- PIX_W, 8, pixel width in bits.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_in  in  PIX_W  incoming pixel, raster order.
- pix_valid  in  1  pix_in is accepted this cycle. No backpressure.
- sw_pixel_1..sw_pixel_9  out  PIX_W each  window. Index = 3*row+col+1.
  - Row 0 is the oldest line, column 0 is the oldest column.
  - sw_pixel_1 is top-left, sw_pixel_5 is the centre, sw_pixel_9 is the newest pixel.
- act  out  1  window outputs form a complete in-image window this cycle.

Behaviour:
- Reset, synchronous active-high:
  - col_cnt=0, row_cnt=0, act=0, all sw_pixel_n=0.
  - Line buffer RAM contents are not cleared; stale data is never exposed because act is gated.
  - rst has priority over pix_valid in the same cycle.
- Storage:
  - Two IMG_WIDTH x PIX_W line buffers, lb1 (line r-1) and lb2 (line r-2), addressed by col_cnt.
  - 3x3 register window.
- On a clock with pix_valid=1:
  - Window shifts one column left: sw_pixel_1<=sw_pixel_2, sw_pixel_2<=sw_pixel_3, and likewise for rows 1 and 2.
  - New right column: sw_pixel_3<=lb2[col_cnt], sw_pixel_6<=lb1[col_cnt], sw_pixel_9<=pix_in. Read-before-write at the same address.
  - lb2[col_cnt]<=lb1[col_cnt] (old value) and lb1[col_cnt]<=pix_in.
  - act<=1 iff row_cnt>=2 and col_cnt>=2, using counter values before increment.
  - col_cnt increments. At IMG_WIDTH-1 it wraps to 0 and row_cnt increments.
  - row_cnt wraps to 0 after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1). The next pixel starts a new frame with no idle cycle required.
- On a clock with pix_valid=0: window, counters and buffers hold; act<=0.
- Latency: act and the window are valid 1 cycle after the clock that accepted the pixel completing the window.
- act is a single-cycle strobe per accepted pixel; consecutive valid pixels give consecutive act cycles.
- Line wrap: windows straddling a line boundary (col_cnt 0,1) never assert act, though the window registers still shift.
- Frame boundary: rows 0 and 1 of a new frame never assert act. Windows never mix frames in an active cycle.
- Reset mid-frame: the next valid pixel is treated as (row 0, col 0). No act until a full 3x3 of post-reset pixels exists.

Optional Feature:
- Macro FRAME_SYNC_EN.
- When defined: adds input port sof (1 bit).
  - A pixel accepted with pix_valid=1 and sof=1 is forced to position (row 0, col 0), whatever the counter state.
  - Counters continue from there: col_cnt=1, row_cnt=0 after that clock. act follows the normal rule with row_cnt=0, so it is 0.
  - sof with pix_valid=0 is ignored.
- When not defined: no sof port. Position comes only from the counters.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4, pixel values 0..15 in raster order):
- Continuous frame, pix_valid held high for 16 cycles:
  - Exactly 4 act pulses. The first comes the cycle after pixel 10, with window 0,1,2,4,5,6,8,9,10.
  - Subsequent windows have centres 6, 9, 10. The last window is 5,6,7,9,10,11,13,14,15.
- Same frame with pix_valid=0 for 1-3 random cycles between pixels:
  - Identical 4 windows in the same order.
  - act is asserted only on the cycle after a valid pixel, and the window is stable during bubbles.
- Two back-to-back frames (second frame values 100..115):
  - 8 act pulses. Fifth window is 100,101,102,104,105,106,108,109,110.
  - No act while row_cnt<2 of frame 2.
- rst for 1 cycle after pixel 6, then values 0..15 resent:
  - act=0 and all sw_pixel=0 the cycle after rst.
  - Then exactly the 4 windows of scenario 1.
- rst asserted together with pix_valid=1 (value 99):
  - The pixel is discarded, counters are 0, and the next frame produces the scenario 1 windows.
- FRAME_SYNC_EN: send pixels 0..5, then values 0..15 with sof on the first:
  - Scenario 1 windows are produced exactly, and no act occurs before pixel 10 of the resynced frame.
